// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: redirect encodings,
// FSM state encoding and the default reset fetch address.
package fetch_pc_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    REDIR_JUMP   = 2'b00,
    REDIR_BRANCH = 2'b01,
    REDIR_REG    = 2'b10,
    REDIR_RSVD   = 2'b11
  } redirect_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_VALID = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sequencer_next_pc_target.sv
// Combinational redirect target calculation. Register targets are always
// forced word aligned; misaligned flags a register target whose low bits
// were nonzero. The reserved type yields pc4 and is never used upstream.
module next_pc_target
  import fetch_pc_sequencer_pkg::*;
(
  input  logic [1:0]  redirect_type,
  input  logic [31:0] pc4,
  input  logic [25:0] imm,
  input  logic [31:0] reg_val,
  output logic [31:0] target,
  output logic        misaligned
);

  // Select the target by redirect kind; branch offset wraps modulo 2^32.
  always_comb begin
    target     = pc4;
    misaligned = 1'b0;
    case (redirect_type)
      REDIR_JUMP:   target = {pc4[31:28], imm, 2'b00};
      REDIR_BRANCH: target = pc4 + {{14{imm[15]}}, imm[15:0], 2'b00};
      REDIR_REG: begin
        target     = {reg_val[31:2], 2'b00};
        misaligned = |reg_val[1:0];
      end
      default:      target = pc4;
    endcase
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Instruction fetch PC sequencer. One outstanding fetch at a time:
// IDLE -> REQ (request until ack) -> VALID (hold until decode takes it).
// Handshakes: imem_req/imem_ack completes a fetch in the cycle both are
// high; instr_valid/instr_ready transfers the held instruction in the
// cycle both are high, and instr_valid never drops without a transfer
// unless a redirect kills the instruction.
// Redirects arriving while a fetch is outstanding are parked in a
// pending slot (last one wins) so imem_addr stays stable until the ack;
// the returning data is then discarded. The FSM state is kept in the
// typed signal 'state' for checkers to bind to.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_type,
  input  logic [31:0] redirect_pc4,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] redirect_reg,
  output logic        misalign_err
);

  fetch_state_t state;
  fetch_state_t state_next;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pending_valid;
  logic [31:0] pending_pc;
  logic [31:0] redir_target;
  logic        redir_misaligned;
  logic        redir_take;

  next_pc_target u_target (
    .redirect_type (redirect_type),
    .pc4           (redirect_pc4),
    .imm           (redirect_imm),
    .reg_val       (redirect_reg),
    .target        (redir_target),
    .misaligned    (redir_misaligned)
  );

  assign redir_take = redirect_valid && (redirect_type != REDIR_RSVD);
  assign pc_plus4   = pc + 32'd4;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: only a clean ack (no redirect, nothing pending)
  // delivers an instruction.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_REQ;
      ST_REQ:   if (imem_ack && !redir_take && !pending_valid) state_next = ST_VALID;
      ST_VALID: if (redir_take || instr_ready) state_next = ST_REQ;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: request is driven straight from the current PC.
  always_comb begin
    imem_req  = (state == ST_REQ);
    imem_addr = pc;
  end

  // PC, pending redirect slot, delivered instruction and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      pending_valid <= 1'b0;
      pending_pc    <= 32'h0;
      instr_valid   <= 1'b0;
      instr_out     <= 32'h0;
      pc_plus4_out  <= 32'h0;
      misalign_err  <= 1'b0;
    end else begin
      misalign_err <= redir_take && redir_misaligned;
      case (state)
        ST_IDLE: begin
          if (redir_take) pc <= redir_target;
        end
        ST_REQ: begin
          if (redir_take) begin
            if (imem_ack) begin
              pc            <= redir_target;
              pending_valid <= 1'b0;
            end else begin
              pending_valid <= 1'b1;
              pending_pc    <= redir_target;
            end
          end else if (imem_ack) begin
            if (pending_valid) begin
              pc            <= pending_pc;
              pending_valid <= 1'b0;
            end else begin
              instr_out    <= imem_rdata;
              pc_plus4_out <= pc_plus4;
              pc           <= pc_plus4;
              instr_valid  <= 1'b1;
            end
          end
        end
        ST_VALID: begin
          if (redir_take) begin
            pc          <= redir_target;
            instr_valid <= 1'b0;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer. Inputs change 1 time unit after the rising
// edge; the monitor samples on the falling edge and checks every accepted
// fetch address, every delivered instruction and every misalign pulse
// against expected queues filled by the stimulus. Memory returns ~addr.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_plus4_out;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_type = 2'b00;
  logic [31:0] redirect_pc4 = 32'h0;
  logic [25:0] redirect_imm = 26'h0;
  logic [31:0] redirect_reg = 32'h0;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc4_q[$];
  logic [31:0] exp_mis_q[$];

  assign imem_rdata = ~imem_addr;

  fetch_pc_sequencer #(.RESET_PC(32'h0040_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_plus4_out   (pc_plus4_out),
    .redirect_valid (redirect_valid),
    .redirect_type  (redirect_type),
    .redirect_pc4   (redirect_pc4),
    .redirect_imm   (redirect_imm),
    .redirect_reg   (redirect_reg),
    .misalign_err   (misalign_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_ack) begin
        if (exp_addr_q.size() == 0) unexpected("fetch_addr", imem_addr);
        else chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (instr_valid && instr_ready && !(redirect_valid && redirect_type != 2'b11)) begin
        if (exp_instr_q.size() == 0) unexpected("instr_out", instr_out);
        else begin
          chk("instr_out", instr_out, exp_instr_q.pop_front());
          chk("pc_plus4_out", pc_plus4_out, exp_pc4_q.pop_front());
        end
      end
      if (misalign_err) begin
        if (exp_mis_q.size() == 0) unexpected("misalign_err", imem_addr);
        else chk("misalign_addr", imem_addr, exp_mis_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && !imem_req; i++) tick();
    if (!imem_req) unexpected("req_timeout", imem_addr);
  endtask

  task automatic fetch(input int delay);
    wait_req();
    repeat (delay) tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic accept();
    for (int i = 0; i < 50 && !instr_valid; i++) tick();
    if (!instr_valid) unexpected("valid_timeout", instr_out);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic redirect(input logic [1:0] t, input logic [31:0] pc4,
                          input logic [25:0] imm, input logic [31:0] r);
    redirect_valid = 1'b1;
    redirect_type  = t;
    redirect_pc4   = pc4;
    redirect_imm   = imm;
    redirect_reg   = r;
  endtask

  task automatic expect_instr(input logic [31:0] addr, input logic [31:0] pc4);
    exp_addr_q.push_back(addr);
    exp_instr_q.push_back(~addr);
    exp_pc4_q.push_back(pc4);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, {31'h0, imem_req}, 32'h0);
    chk({tag, "_instr_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_instr_out"}, instr_out, 32'h0);
    chk({tag, "_pc_plus4_out"}, pc_plus4_out, 32'h0);
    chk({tag, "_misalign_err"}, {31'h0, misalign_err}, 32'h0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0040_0000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("idle_to_req", {31'h0, imem_req}, 32'h1);

    // Sequential fetch, ack every request, decode always ready.
    expect_instr(32'h0040_0000, 32'h0040_0004);
    expect_instr(32'h0040_0004, 32'h0040_0008);
    expect_instr(32'h0040_0008, 32'h0040_000C);
    for (int i = 0; i < 3; i++) begin
      fetch(0);
      accept();
    end

    // Jump while an instruction is held (decode not ready).
    exp_addr_q.push_back(32'h0040_000C);
    fetch(0);
    chk("held_valid", {31'h0, instr_valid}, 32'h1);
    redirect(2'b00, 32'h1000_0010, 26'h0000040, 32'h0);
    tick();
    redirect_valid = 1'b0;
    chk("jump_kill_valid", {31'h0, instr_valid}, 32'h0);
    chk("jump_addr", imem_addr, 32'h1000_0100);
    expect_instr(32'h1000_0100, 32'h1000_0104);
    fetch(0);
    accept();

    // Backward branch while the fetch is stalled three cycles.
    wait_req();
    redirect(2'b01, 32'h0040_0010, 26'h000FFFC, 32'h0);
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr_hold", imem_addr, 32'h1000_0104);
      if (i < 2) tick();
    end
    exp_addr_q.push_back(32'h1000_0104);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("branch_discard", {31'h0, instr_valid}, 32'h0);
    expect_instr(32'h0040_0000, 32'h0040_0004);
    fetch(0);
    accept();

    // Two redirects before the ack: the register one wins.
    wait_req();
    redirect(2'b00, 32'h2000_0000, 26'h0000010, 32'h0);
    tick();
    redirect(2'b10, 32'h0, 26'h0, 32'h0040_0200);
    tick();
    redirect_valid = 1'b0;
    exp_addr_q.push_back(32'h0040_0004);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("double_discard", {31'h0, instr_valid}, 32'h0);
    expect_instr(32'h0040_0200, 32'h0040_0204);
    fetch(0);
    accept();

    // Misaligned register target with same-cycle ack.
    wait_req();
    exp_addr_q.push_back(32'h0040_0204);
    exp_mis_q.push_back(32'h0040_0200);
    redirect(2'b10, 32'h0, 26'h0, 32'h0040_0203);
    imem_ack = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    expect_instr(32'h0040_0200, 32'h0040_0204);
    fetch(0);
    accept();

    // Fetch at the top of the address space; PC+4 wraps to zero.
    wait_req();
    exp_addr_q.push_back(32'h0040_0204);
    redirect(2'b10, 32'h0, 26'h0, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    expect_instr(32'hFFFF_FFFC, 32'h0000_0000);
    fetch(0);
    accept();

    // Reserved redirect type alongside an ack is ignored entirely.
    wait_req();
    expect_instr(32'h0000_0000, 32'h0000_0004);
    redirect(2'b11, 32'h0, 26'h0, 32'h0000_0103);
    imem_ack = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    accept();

    // Reset while requesting with decode not ready; late ack after release.
    wait_req();
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    tick();
    tick();
    rst = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("restart_req", {31'h0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr, 32'h0040_0000);
    expect_instr(32'h0040_0000, 32'h0040_0004);
    fetch(0);
    accept();

    // Redirect landing in IDLE right after reset release.
    wait_req();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    redirect(2'b10, 32'h0, 26'h0, 32'h0040_0100);
    tick();
    redirect_valid = 1'b0;
    expect_instr(32'h0040_0100, 32'h0040_0104);
    fetch(1);
    accept();

    tick();
    tick();
    chk("addr_q_empty", exp_addr_q.size(), 32'd0);
    chk("instr_q_empty", exp_instr_q.size(), 32'd0);
    chk("mis_q_empty", exp_mis_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_sequencer.md
FETCH_PC_SEQUENCER -- requirements
Module: fetch_pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, SHALL set the first fetch address after reset.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous, active-high reset
  imem_req  out  1  fetch request to instruction memory
  imem_addr  out  32  fetch address, word aligned
  imem_ack  in  1  memory accepted request; imem_rdata valid same cycle
  imem_rdata  in  32  fetched instruction
  instr_valid  out  1  instr_out/pc_plus4_out valid
  instr_ready  in  1  decode accepts instruction
  instr_out  out  32  fetched instruction
  pc_plus4_out  out  32  fetch address + 4 for the held instruction
  redirect_valid  in  1  one-cycle redirect pulse
  redirect_type  in  2  00 jump, 01 branch, 10 register, 11 reserved (ignored)
  redirect_pc4  in  32  PC+4 of the redirecting instruction
  redirect_imm  in  26  jump index [25:0]; branch offset uses [15:0]
  redirect_reg  in  32  register target (jr/jalr)
  misalign_err  out  1  one-cycle pulse: register target low bits nonzero
REQ-003 Reset SHALL be one clock, asynchronous and active-high, named clk and rst.

Function
REQ-004 Target SHALL be: jump {redirect_pc4[31:28], redirect_imm, 2'b00}; branch redirect_pc4 + (sign-extended redirect_imm[15:0] << 2), modulo 2^32; register {redirect_reg[31:2], 2'b00}.
REQ-005 FSM states SHALL be IDLE, REQ, VALID; IDLE -> REQ unconditionally on the first clock after reset release.
REQ-006 In REQ, imem_req=1 and imem_addr=pc; address SHALL stay stable until imem_ack.
REQ-007 REQ with imem_ack and no redirect/pending: instr_out<=imem_rdata, pc_plus4_out<=pc+4, pc<=pc+4, instr_valid<=1, go VALID.
REQ-008 In VALID, outputs SHALL hold until instr_ready=1, then instr_valid<=0, go REQ (one bubble cycle per instruction).
REQ-009 pc+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
REQ-010 Redirect in IDLE: pc<=target; sequencing unchanged.
REQ-011 Redirect in REQ with imem_ack same cycle: discard imem_rdata, pc<=target, stay REQ.
REQ-012 Redirect in REQ without imem_ack: latch target as pending; on later ack discard data, pc<=pending target, clear pending, stay REQ.
REQ-013 Multiple redirects before ack: last one SHALL win.
REQ-014 Redirect in VALID: instr_valid<=0 next cycle regardless of instr_ready, pc<=target, go REQ.
REQ-015 redirect_type 11 SHALL be ignored entirely.
REQ-016 Register redirect with redirect_reg[1:0]!=0: misalign_err pulses one cycle, target forced aligned per REQ-004.

Reset
REQ-017 On rst: state=IDLE, pc=RESET_PC, pending cleared, imem_req=0, instr_valid=0, instr_out=0, pc_plus4_out=0, misalign_err=0.
REQ-018 rst mid-transaction SHALL abandon the request; a late imem_ack after release SHALL be ignored unless in REQ.

Structure
REQ-019 Shared package SHALL hold redirect_type encodings, FSM state encoding, RESET_PC default.
REQ-020 Target calculation SHALL be a combinational sub-module next_pc_target (type, pc4, imm, reg -> target, misaligned).

Verification
REQ-021 Reset release, ack every REQ cycle, ready=1: imem_addr 0x00400000, 0x00400004, 0x00400008 on successive REQ cycles.
REQ-022 Jump, redirect_pc4=0x10000010, imm=26'h0000040 in VALID -> instr_valid low next cycle, next imem_addr 0x10000100.
REQ-023 Branch, pc4=0x00400010, imm[15:0]=16'hFFFC in REQ with ack delayed 3 cycles -> addr held, data discarded, next addr 0x00400000.
REQ-024 Two redirects (jump then register 0x00400200) before ack -> next addr 0x00400200, no instruction delivered.
REQ-025 Register redirect 0x00400203 -> misalign_err one pulse, next addr 0x00400200; pc=0xFFFFFFFC fetch -> pc_plus4_out 0x00000000.
REQ-026 rst asserted while imem_req=1 and instr_ready=0 -> all outputs reset values immediately, fetch restarts at RESET_PC.
